ballot_unit: RTL
================

// Module: ballot_unit
// PURPOSE
//  Voter-facing front end of the EVM, directly upstream of the vote counter.
//  - Arms for exactly one vote per authenticated voter.
//  - Debounces the four party buttons.
//  - Emits a single-cycle control strobe with incr_party_vote, which the counter accumulates.
//  - Enforces one-vote-per-ID, timeout and abort rules, so the counter only ever sees clean strobes.
// PARAMETERS
//  DEBOUNCE_CYCLES  4     consecutive stable samples before a button level is accepted (>=2)
//  TIMEOUT_CYCLES   1000  cycles in ARMED with no accepted press before the session is dropped
//  CNT_W            7     width of votes_cast; matches counter total_voting width
// PORTS
//  clk              in   1      system clock, all logic on posedge
//  reset            in   1      asynchronous, active-low reset
//  mode             in   1      1 = voting mode, 0 = result mode (voting disabled)
//  id_valid         in   1      1-cycle pulse: voter ID authenticated by the booth officer
//  reset_id_status  in   1      synchronous abort: drop the current voter session
//  btn              in   4      raw, asynchronous party buttons; btn[i] maps to party i
//  control          out  1      1-cycle vote strobe to the counter
//  incr_party_vote  out  2      party index; valid only while control=1, otherwise holds the last value
//  ready_lamp       out  1      1 while ARMED (voter may press)
//  busy             out  1      1 in any state other than IDLE
//  timeout_err      out  1      1-cycle pulse when an ARMED session expires
//  votes_cast       out  CNT_W  number of strobes issued since reset; saturates at 2^CNT_W-1
// BEHAVIOUR
//  Reset (reset=0, asynchronous)
//  - State goes to IDLE.
//  - control=0, incr_party_vote=0, ready_lamp=0, busy=0, timeout_err=0, votes_cast=0.
//  - Synchronisers and debouncers are cleared to 0.
//  Button conditioning
//  - Each btn bit passes through a 2-FF synchroniser.
//  - The debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronised samples.
//  - A press event is a debounced rising edge.
//  FSM states
//  - IDLE -> ARMED on id_valid=1 and mode=1. An id_valid in any other state is ignored.
//  - ARMED:
//      * Exactly one press event with no other debounced button high -> CAST.
//      * Presses with two or more debounced buttons high are ignored; remain ARMED.
//      * A button already held when ARMED is entered is not a press; it must be released and re-pressed.
//      * Timer reaches TIMEOUT_CYCLES -> IDLE with timeout_err=1 for 1 cycle.
//  - CAST (1 cycle):
//      * control=1 and incr_party_vote=index of the pressed button.
//      * votes_cast increments (saturating).
//      * -> LOCKED.
//  - LOCKED: waits until all debounced buttons are 0, then -> IDLE. No further strobes are issued.
//  Latency
//  - Raw btn rising edge stable from sample edge N gives control=1 in cycle N+DEBOUNCE_CYCLES+3, exactly.
//  Abort and priority
//  - reset_id_status=1 or mode=0 in ARMED or LOCKED -> IDLE next cycle, with no strobe and no timeout_err.
//  - reset_id_status=1 or mode=0 has priority over a simultaneous press event or timeout.
//  - In CAST, the strobe always completes: a same-cycle abort does not suppress control.
//  - A press event and timer expiry in the same cycle: the press wins, timeout_err=0.
//  Invariants
//  - At most one control strobe per id_valid.
//  - control is never 1 for 2 consecutive cycles.
//  - control is never 1 while mode=0.
// STRUCTURE
//  - Shared package/include evm_pkg:
//      * state encoding: IDLE=0, ARMED=1, CAST=2, LOCKED=3
//      * party index width (2)
//      * CNT_W default
//  - Sub-module evm_debounce: synchroniser plus stable-count filter for one bit, parameter DEBOUNCE_CYCLES.
//    Instantiate it 4 times.
//  - Top level holds: FSM, timeout counter (clog2(TIMEOUT_CYCLES) bits), press-edge/one-hot check, votes_cast.
// TESTING
//  - Clean vote: id_valid, then btn=4'b0100 held for 10 cycles.
//      -> exactly one control pulse, incr_party_vote=2, votes_cast=1, ready_lamp falls.
//  - Bounce: btn[1] toggled every cycle for 3 cycles, then held.
//      -> exactly one strobe with index 1, at fixed latency counted from the final stable edge.
//  - Double vote: after a strobe, btn[0] pressed again with no new id_valid -> no strobe, votes_cast unchanged.
//  - Multi-press: btn=4'b0011 while ARMED -> no strobe; release, then btn=4'b1000 -> index 3.
//  - Timeout with TIMEOUT_CYCLES=20: id_valid and no press.
//      -> timeout_err pulse 20 cycles later, busy=0, no strobe.
//  - Abort: mode=0 mid-ARMED, then reset=0 mid-LOCKED.
//      -> IDLE, all outputs at reset values, votes_cast=0 after reset.

Source files
------------

// File: rtl/evm_pkg.sv
// Shared definitions for the EVM ballot front end: FSM encoding, party
// index width and the default vote-count width.
package evm_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ARMED  = 2'd1,
      S_CAST   = 2'd2,
      S_LOCKED = 2'd3
   } state_e;

   localparam int PARTY_W   = 2;
   localparam int N_PARTY   = 4;
   localparam int CNT_W_DEF = 7;

   // Index of the single high bit of a one-hot party vector.
   function automatic logic [PARTY_W-1:0] party_index(input logic [N_PARTY-1:0] onehot);
      party_index = '0;
      for (int i = 0; i < N_PARTY; i++) begin
         if (onehot[i]) party_index = PARTY_W'(i);
      end
   endfunction

endpackage

// File: rtl/evm_debounce.sv
// One-bit button conditioner: 2-FF synchroniser followed by a filter that
// accepts a new level only after DEBOUNCE_CYCLES consecutive equal samples.
module evm_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_raw,
   output logic o_level
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic [CW-1:0] r_cnt;

   // NOTE: all state updates are non-blocking so every flop samples the
   // pre-edge value of its neighbour; blocking here would collapse the
   // synchroniser into a single stage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_level = r_level;

endmodule

// File: rtl/ballot_unit.sv
// Voter-facing ballot front end: arms once per authenticated voter, turns a
// single clean button press into one control strobe for the vote counter.
module ballot_unit
   import evm_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TIMEOUT_CYCLES  = 1000,
   parameter int CNT_W           = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               mode,
   input  logic               id_valid,
   input  logic               reset_id_status,
   input  logic [N_PARTY-1:0] btn,
   output logic               control,
   output logic [PARTY_W-1:0] incr_party_vote,
   output logic               ready_lamp,
   output logic               busy,
   output logic               timeout_err,
   output logic [CNT_W-1:0]   votes_cast
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] VOTES_MAX = '1;

   logic [N_PARTY-1:0] w_deb;
   logic [N_PARTY-1:0] w_press;
   logic               w_valid_press;
   logic               w_abort;
   logic [N_PARTY-1:0] r_deb_prev;
   state_e             r_state;
   logic [TW-1:0]      r_timer;

   for (genvar g = 0; g < N_PARTY; g++) begin : g_btn
      evm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk     (clk),
         .reset   (reset),
         .i_raw   (btn[g]),
         .o_level (w_deb[g])
      );
   end

   // A press counts only as a debounced rising edge, so a button already held
   // on arming never fires; it must be released and pressed again.
   assign w_press       = w_deb & ~r_deb_prev;
   assign w_valid_press = (w_press != '0) && $onehot(w_deb);
   assign w_abort       = reset_id_status || !mode;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state         <= S_IDLE;
         r_timer         <= '0;
         r_deb_prev      <= '0;
         control         <= 1'b0;
         incr_party_vote <= '0;
         ready_lamp      <= 1'b0;
         busy            <= 1'b0;
         timeout_err     <= 1'b0;
         votes_cast      <= '0;
      end else begin
         r_deb_prev  <= w_deb;
         control     <= 1'b0;
         timeout_err <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (id_valid && mode) begin
                  r_state    <= S_ARMED;
                  r_timer    <= '0;
                  ready_lamp <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            S_ARMED: begin
               if (w_abort) begin
                  r_state    <= S_IDLE;
                  ready_lamp <= 1'b0;
                  busy       <= 1'b0;
               end else if (w_valid_press) begin
                  r_state         <= S_CAST;
                  ready_lamp      <= 1'b0;
                  control         <= 1'b1;
                  incr_party_vote <= party_index(w_deb);
                  if (votes_cast != VOTES_MAX) votes_cast <= votes_cast + CNT_W'(1);
               end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
                  r_state     <= S_IDLE;
                  ready_lamp  <= 1'b0;
                  busy        <= 1'b0;
                  timeout_err <= 1'b1;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            S_CAST: begin
               // The strobe is already on the wire; an abort here only ends the session.
               r_state <= w_abort ? S_IDLE : S_LOCKED;
               busy    <= !w_abort;
            end
            S_LOCKED: begin
               if (w_abort || (w_deb == '0)) begin
                  r_state <= S_IDLE;
                  busy    <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
